// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the register-bank access controller
package regfile_pkg;

  localparam int NUM_REGS_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    ALU_RD,
    ALU_WAIT,
    ALU_WR,
    MEM_RD,
    MEM_WR
  } regfile_state_t;

  typedef enum logic {
    REQ_ALU,
    REQ_MEM
  } req_id_t;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - index plus enable to one-hot strobe vector
module onehot_decoder #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]      idx,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  // set exactly the indexed bit when enabled, otherwise all zero
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - arbiter and strobe sequencer for the shared register bank
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_req_valid,
  input  logic [ADDR_W-1:0]   alu_ra,
  input  logic [ADDR_W-1:0]   alu_rb,
  input  logic [ADDR_W-1:0]   alu_rd,
  output logic                alu_req_ready,
  output logic                alu_opnd_valid,
  input  logic                alu_res_valid,
  input  logic                mem_req_valid,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_reg,
  output logic                mem_req_ready,
  output logic                mem_done,
  output logic [NUM_REGS-1:0] load,
  output logic [NUM_REGS-1:0] out0_en,
  output logic [NUM_REGS-1:0] out1_en,
  output logic                wr_src_sel
);

  regfile_state_t    state;
  req_id_t           rr_last;
  logic [ADDR_W-1:0] rd0_idx;
  logic [ADDR_W-1:0] rd1_idx;
  logic [ADDR_W-1:0] ld_idx;
  logic              rd0_on;
  logic              rd1_on;
  logic              ld_on;
  logic              grant_alu;
  logic              grant_mem;

  // on a tie the requester that did not win last time gets the bank
  assign grant_alu = alu_req_valid && (!mem_req_valid || (rr_last == REQ_MEM));
  assign grant_mem = mem_req_valid && !grant_alu;

  // FSM: outputs are registered together with the state they belong to,
  // so every strobe is stable for a whole cycle starting at posedge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_last        <= REQ_MEM;
      rd0_idx        <= '0;
      rd1_idx        <= '0;
      ld_idx         <= '0;
      rd0_on         <= 1'b0;
      rd1_on         <= 1'b0;
      ld_on          <= 1'b0;
      alu_req_ready  <= 1'b0;
      alu_opnd_valid <= 1'b0;
      mem_req_ready  <= 1'b0;
      mem_done       <= 1'b0;
      wr_src_sel     <= 1'b0;
    end else begin
      alu_req_ready  <= 1'b0;
      alu_opnd_valid <= 1'b0;
      mem_req_ready  <= 1'b0;
      mem_done       <= 1'b0;
      rd0_on         <= 1'b0;
      rd1_on         <= 1'b0;
      ld_on          <= 1'b0;
      wr_src_sel     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_alu) begin
            state          <= ALU_RD;
            rr_last        <= REQ_ALU;
            alu_req_ready  <= 1'b1;
            alu_opnd_valid <= 1'b1;
            rd0_idx        <= alu_ra;
            rd1_idx        <= alu_rb;
            ld_idx         <= alu_rd;
            rd0_on         <= 1'b1;
            rd1_on         <= 1'b1;
          end else if (grant_mem) begin
            rr_last       <= REQ_MEM;
            mem_req_ready <= 1'b1;
            mem_done      <= 1'b1;
            if (mem_we) begin
              state      <= MEM_WR;
              ld_idx     <= mem_reg;
              ld_on      <= 1'b1;
              wr_src_sel <= 1'b1;
            end else begin
              state   <= MEM_RD;
              rd0_idx <= mem_reg;
              rd0_on  <= 1'b1;
            end
          end
        end
        ALU_RD: begin
          state <= ALU_WAIT;
        end
        ALU_WAIT: begin
          if (alu_res_valid) begin
            state <= ALU_WR;
            ld_on <= 1'b1;
          end
        end
        ALU_WR, MEM_RD, MEM_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  onehot_decoder #(.ADDR_W(ADDR_W)) u_load_dec (
    .idx    (ld_idx),
    .en     (ld_on),
    .onehot (load)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_out0_dec (
    .idx    (rd0_idx),
    .en     (rd0_on),
    .onehot (out0_en)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_out1_dec (
    .idx    (rd1_idx),
    .en     (rd1_on),
    .onehot (out1_en)
  );

  // bus-protocol invariants: single driver per bus, no read/write overlap
  a_load_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(load));
  a_out0_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(out0_en));
  a_out1_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(out1_en));
  a_load_excl:    assert property (@(posedge clk) disable iff (reset)
                                   !((|load) && ((|out0_en) || (|out1_en))));
  a_out1_alu_rd:  assert property (@(posedge clk) disable iff (reset)
                                   (|out1_en) |-> (state == ALU_RD));

endmodule
